// File: rtl/fcore_multicycle_alu.sv
// fcore_multicycle_alu
//
// Parametrised integer ALU for the fcore datapath. One operation issues when
// operand A, operand B and the opcode are all valid on the same cycle and the
// issue port is ready. Logic, add, shift and compare ops take one cycle. The
// multiply is pipelined with MUL_LATENCY cycles from issue to result. Every
// result leaves on one writeback stream, tagged with the destination register
// address that arrived on operand A's user field.
//
// The writeback register is one slot per cycle. A fast op issued now lands on
// the same cycle as a multiply issued MUL_LATENCY-1 cycles ago, so a fast op
// is held while that multiply is in the last pipeline stage. Multiplies are
// never held.
//
// Ports
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_a_valid/o_a_ready/i_a_data  operand A stream, i_a_user = destination address
//   i_b_valid/o_b_ready/i_b_data  operand B stream
//   i_op_valid/o_op_ready/i_op_data  opcode stream (4-bit opcode)
//   o_res_valid/o_res_data/o_res_user  result stream; i_res_ready is ignored
//   o_overflow                   pulse alongside o_res_valid on add/sub/mul overflow
//   o_illegal_op                 one-cycle pulse after an undefined opcode is consumed
//
// Legal MUL_LATENCY range is 2..8.
module fcore_multicycle_alu #(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned REGISTER_ADDR_WIDTH = 8,
  parameter int unsigned MUL_LATENCY         = 3,
  parameter bit          SATURATE            = 1'b0
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  // operand A
  input  logic                           i_a_valid,
  output logic                           o_a_ready,
  input  logic [DATA_WIDTH-1:0]          i_a_data,
  input  logic [REGISTER_ADDR_WIDTH-1:0] i_a_user,
  // operand B
  input  logic                           i_b_valid,
  output logic                           o_b_ready,
  input  logic [DATA_WIDTH-1:0]          i_b_data,
  // opcode
  input  logic                           i_op_valid,
  output logic                           o_op_ready,
  input  logic [3:0]                     i_op_data,
  // result
  output logic                           o_res_valid,
  input  logic                           i_res_ready,
  output logic [DATA_WIDTH-1:0]          o_res_data,
  output logic [REGISTER_ADDR_WIDTH-1:0] o_res_user,
  // status
  output logic                           o_overflow,
  output logic                           o_illegal_op
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned AW  = REGISTER_ADDR_WIDTH;
  localparam int unsigned ShW = $clog2(DATA_WIDTH);

  localparam logic [DW-1:0] MaxVal = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MinVal = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpMul   = 4'd2,
    OpAnd   = 4'd3,
    OpOr    = 4'd4,
    OpXor   = 4'd5,
    OpShl   = 4'd6,
    OpSar   = 4'd7,
    OpCmpgt = 4'd8
  } opcode_e;

  // The result stream has no back-pressure; ready is accepted but unused.
  logic w_unused_res_ready;
  assign w_unused_res_ready = i_res_ready;

  // --------------------------------------------------------------------------
  // Opcode decode and issue handshake
  // --------------------------------------------------------------------------
  opcode_e w_opcode;
  logic    w_is_fast;
  logic    w_is_mul;
  logic    w_is_illegal;
  logic    w_issue_ready;
  logic    w_fire;
  logic    w_fast_fire;
  logic    w_mul_fire;

  // r_mul_vld[k] set means a multiply issued k cycles ago is in flight.
  logic [MUL_LATENCY-1:1] r_mul_vld;

  assign w_opcode = opcode_e'(i_op_data);

  always_comb begin
    w_is_fast    = 1'b0;
    w_is_mul     = 1'b0;
    w_is_illegal = 1'b0;
    case (w_opcode)
      OpMul:                                            w_is_mul  = 1'b1;
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpSar, OpCmpgt: w_is_fast = 1'b1;
      default:                                          w_is_illegal = 1'b1;
    endcase
  end

  // Hold a fast op only when its writeback slot is already owned by a multiply.
  assign w_issue_ready = !(w_is_fast && r_mul_vld[MUL_LATENCY-1]);

  assign o_a_ready  = w_issue_ready;
  assign o_b_ready  = w_issue_ready;
  assign o_op_ready = w_issue_ready;

  assign w_fire      = i_a_valid && i_b_valid && i_op_valid && w_issue_ready;
  assign w_fast_fire = w_fire && w_is_fast;
  assign w_mul_fire  = w_fire && w_is_mul;

  // --------------------------------------------------------------------------
  // Fast datapath
  // --------------------------------------------------------------------------
  // Narrow a DW+1 bit add/sub result, clamping when the two top bits disagree.
  function automatic logic [DW-1:0] f_narrow(input logic [DW:0] v);
    if (SATURATE && (v[DW] != v[DW-1])) begin
      return v[DW] ? MinVal : MaxVal;
    end
    return v[DW-1:0];
  endfunction

  logic [DW:0]     w_a_ext;
  logic [DW:0]     w_b_ext;
  logic [DW:0]     w_sum;
  logic [DW:0]     w_diff;
  logic [ShW-1:0]  w_shamt;
  logic            w_gt;
  logic [DW-1:0]   w_fast_res;
  logic            w_fast_ovf;

  assign w_a_ext = {i_a_data[DW-1], i_a_data};
  assign w_b_ext = {i_b_data[DW-1], i_b_data};
  assign w_sum   = w_a_ext + w_b_ext;
  assign w_diff  = w_a_ext - w_b_ext;
  assign w_shamt = i_b_data[ShW-1:0];
  assign w_gt    = $signed(i_a_data) > $signed(i_b_data);

  always_comb begin
    w_fast_res = '0;
    w_fast_ovf = 1'b0;
    case (w_opcode)
      OpAdd: begin
        w_fast_res = f_narrow(w_sum);
        w_fast_ovf = w_sum[DW] ^ w_sum[DW-1];
      end
      OpSub: begin
        w_fast_res = f_narrow(w_diff);
        w_fast_ovf = w_diff[DW] ^ w_diff[DW-1];
      end
      OpAnd:   w_fast_res = i_a_data & i_b_data;
      OpOr:    w_fast_res = i_a_data | i_b_data;
      OpXor:   w_fast_res = i_a_data ^ i_b_data;
      OpShl:   w_fast_res = i_a_data << w_shamt;
      OpSar:   w_fast_res = $signed(i_a_data) >>> w_shamt;
      OpCmpgt: w_fast_res = {{(DW-1){1'b0}}, w_gt};
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Multiply pipeline
  // --------------------------------------------------------------------------
  // The full product is formed at issue and carried down the pipeline; the
  // overflow check and clamp happen on the way into the writeback register.
  logic [2*DW-1:0] w_prod;
  logic [2*DW-1:0] r_mul_prod [1:MUL_LATENCY-1];
  logic [AW-1:0]   r_mul_user [1:MUL_LATENCY-1];

  assign w_prod = $signed({{DW{i_a_data[DW-1]}}, i_a_data})
                * $signed({{DW{i_b_data[DW-1]}}, i_b_data});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mul_vld <= '0;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        r_mul_prod[k] <= '0;
        r_mul_user[k] <= '0;
      end
    end else begin
      r_mul_vld[1]  <= w_mul_fire;
      r_mul_prod[1] <= w_prod;
      r_mul_user[1] <= i_a_user;
      for (int k = 2; k < MUL_LATENCY; k++) begin
        r_mul_vld[k]  <= r_mul_vld[k-1];
        r_mul_prod[k] <= r_mul_prod[k-1];
        r_mul_user[k] <= r_mul_user[k-1];
      end
    end
  end

  logic            w_mul_done;
  logic [2*DW-1:0] w_mul_tail;
  logic [DW:0]     w_mul_hi;
  logic            w_mul_ovf;
  logic [DW-1:0]   w_mul_res;

  assign w_mul_done = r_mul_vld[MUL_LATENCY-1];
  assign w_mul_tail = r_mul_prod[MUL_LATENCY-1];
  // Product fits when bits 2*DW-1 .. DW-1 are all copies of the sign.
  assign w_mul_hi   = w_mul_tail[2*DW-1:DW-1];
  assign w_mul_ovf  = !((&w_mul_hi) || !(|w_mul_hi));

  always_comb begin
    w_mul_res = w_mul_tail[DW-1:0];
    if (SATURATE && w_mul_ovf) begin
      w_mul_res = w_mul_hi[DW] ? MinVal : MaxVal;
    end
  end

  // --------------------------------------------------------------------------
  // Writeback register
  // --------------------------------------------------------------------------
  // w_fast_fire and w_mul_done are exclusive thanks to the issue hold above.
  logic                r_res_valid;
  logic [DW-1:0]       r_res_data;
  logic [AW-1:0]       r_res_user;
  logic                r_overflow;
  logic                r_illegal_op;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_user   <= '0;
      r_overflow   <= 1'b0;
      r_illegal_op <= 1'b0;
    end else begin
      r_res_valid  <= w_fast_fire || w_mul_done;
      r_overflow   <= (w_fast_fire && w_fast_ovf) || (w_mul_done && w_mul_ovf);
      r_illegal_op <= w_fire && w_is_illegal;
      if (w_fast_fire) begin
        r_res_data <= w_fast_res;
        r_res_user <= i_a_user;
      end else if (w_mul_done) begin
        r_res_data <= w_mul_res;
        r_res_user <= r_mul_user[MUL_LATENCY-1];
      end
    end
  end

  assign o_res_valid  = r_res_valid;
  assign o_res_data   = r_res_data;
  assign o_res_user   = r_res_user;
  assign o_overflow   = r_overflow;
  assign o_illegal_op = r_illegal_op;

endmodule

// File: tb/tb_fcore_multicycle_alu.sv
// Directed bench for fcore_multicycle_alu (DATA_WIDTH=32, MUL_LATENCY=3).
// A wrapping instance is checked through a scoreboard keyed on the expected
// completion cycle; a saturating instance sharing the same inputs is checked
// directly at the cycles where saturation matters.
module tb_fcore_multicycle_alu;

  localparam int unsigned L = 3;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid, op_valid;
  logic [31:0] a_data, b_data;
  logic [7:0]  a_user;
  logic [3:0]  op_data;

  logic        a_ready, b_ready, op_ready;
  logic        res_valid, overflow, illegal_op;
  logic [31:0] res_data;
  logic [7:0]  res_user;

  logic        s_a_ready, s_b_ready, s_op_ready;
  logic        s_res_valid, s_overflow, s_illegal_op;
  logic [31:0] s_res_data;
  logic [7:0]  s_res_user;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  user;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  fcore_multicycle_alu #(
    .DATA_WIDTH(32), .REGISTER_ADDR_WIDTH(8), .MUL_LATENCY(L), .SATURATE(1'b0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_data(a_data), .i_a_user(a_user),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_data(b_data),
    .i_op_valid(op_valid), .o_op_ready(op_ready), .i_op_data(op_data),
    .o_res_valid(res_valid), .i_res_ready(1'b1), .o_res_data(res_data),
    .o_res_user(res_user), .o_overflow(overflow), .o_illegal_op(illegal_op)
  );

  fcore_multicycle_alu #(
    .DATA_WIDTH(32), .REGISTER_ADDR_WIDTH(8), .MUL_LATENCY(L), .SATURATE(1'b1)
  ) u_sat (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .o_a_ready(s_a_ready), .i_a_data(a_data), .i_a_user(a_user),
    .i_b_valid(b_valid), .o_b_ready(s_b_ready), .i_b_data(b_data),
    .i_op_valid(op_valid), .o_op_ready(s_op_ready), .i_op_data(op_data),
    .o_res_valid(s_res_valid), .i_res_ready(1'b1), .o_res_data(s_res_data),
    .o_res_user(s_res_user), .o_overflow(s_overflow), .o_illegal_op(s_illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Present one op for one cycle; queue its result when it is expected to fire.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] user, input logic exp_rdy, input logic push,
                       input logic [31:0] rdata, input logic rovf);
    exp_t e;
    a_valid = 1'b1; b_valid = 1'b1; op_valid = 1'b1;
    op_data = op; a_data = a; b_data = b; a_user = user;
    #1;
    chk("a_ready", a_ready, exp_rdy);
    chk("b_ready", b_ready, exp_rdy);
    chk("op_ready", op_ready, exp_rdy);
    if (push && exp_rdy) begin
      e.data = rdata; e.user = user; e.ovf = rovf;
      e.cyc  = cyc + ((op == 4'd2) ? L : 1);
      sb.push_back(e);
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; op_valid = 1'b0;
  endtask

  // Scoreboard: each result must match the entry due on this cycle.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      int idx;
      idx = -1;
      foreach (sb[i]) if (sb[i].cyc == cyc) idx = i;
      total++;
      assert (idx >= 0) else begin
        bad++;
        $error("FAIL unexpected_result cyc=%0d got data=%0h user=%0h want=none",
               cyc, res_data, res_user);
      end
      if (idx >= 0) begin
        chk("res_data", res_data, sb[idx].data);
        chk("res_user", res_user, sb[idx].user);
        chk("res_ovf", overflow, sb[idx].ovf);
        sb.delete(idx);
      end
    end
  end

  // No cycle may have both a fast op and a multiply claiming writeback.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      total++;
      assert (!(dut.w_fast_fire && dut.w_mul_done)) else begin
        bad++;
        $error("FAIL wb_collision got=1 want=0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; op_valid = 1'b0;
    a_data = '0; b_data = '0; a_user = '0; op_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Reset state
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_data", res_data, 32'h0);
    chk("rst_user", res_user, 8'h0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_illegal", illegal_op, 1'b0);
    chk("rst_ready", a_ready, 1'b1);
    @(negedge clk);

    // Basic ADD and MUL
    issue(4'd0, 32'd5, 32'd7, 8'h12, 1'b1, 1'b1, 32'd12, 1'b0);
    issue(4'd2, 32'hFFFF_FFFD, 32'd4, 8'h05, 1'b1, 1'b1, 32'hFFFF_FFF4, 1'b0);
    repeat (4) @(negedge clk);

    // Writeback hold: MUL at t, ADD presented t+2 is held, issues at t+3
    issue(4'd2, 32'd6, 32'd7, 8'h21, 1'b1, 1'b1, 32'd42, 1'b0);
    @(negedge clk);
    issue(4'd0, 32'd1, 32'd2, 8'h22, 1'b0, 1'b0, 32'd0, 1'b0);
    issue(4'd0, 32'd1, 32'd2, 8'h22, 1'b1, 1'b1, 32'd3, 1'b0);
    repeat (4) @(negedge clk);

    // Add overflow: wrap on dut, clamp on u_sat
    issue(4'd0, 32'h7FFF_FFFF, 32'd1, 8'h30, 1'b1, 1'b1, 32'h8000_0000, 1'b1);
    chk("sat_add_valid", s_res_valid, 1'b1);
    chk("sat_add_data", s_res_data, 32'h7FFF_FFFF);
    chk("sat_add_ovf", s_overflow, 1'b1);
    issue(4'd1, 32'h8000_0000, 32'd1, 8'h31, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1);
    chk("sat_sub_data", s_res_data, 32'h8000_0000);
    chk("sat_sub_ovf", s_overflow, 1'b1);
    @(negedge clk);

    // Multiply overflow: 2^16 * 2^16
    issue(4'd2, 32'h0001_0000, 32'h0001_0000, 8'h32, 1'b1, 1'b1, 32'h0, 1'b1);
    repeat (L - 1) @(negedge clk);
    chk("sat_mul_valid", s_res_valid, 1'b1);
    chk("sat_mul_data", s_res_data, 32'h7FFF_FFFF);
    chk("sat_mul_ovf", s_overflow, 1'b1);
    repeat (2) @(negedge clk);

    // Back-to-back fast ops
    issue(4'd1, 32'd3, 32'd10, 8'h40, 1'b1, 1'b1, 32'hFFFF_FFF9, 1'b0);
    issue(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 8'h41, 1'b1, 1'b1, 32'h00F0_1200, 1'b0);
    issue(4'd4, 32'hF000_0001, 32'h0000_0F10, 8'h42, 1'b1, 1'b1, 32'hF000_0F11, 1'b0);
    issue(4'd5, 32'hAAAA_5555, 32'hFFFF_0000, 8'h43, 1'b1, 1'b1, 32'h5555_5555, 1'b0);
    issue(4'd6, 32'd1, 32'd31, 8'h44, 1'b1, 1'b1, 32'h8000_0000, 1'b0);
    issue(4'd7, 32'h8000_0000, 32'd4, 8'h45, 1'b1, 1'b1, 32'hF800_0000, 1'b0);
    issue(4'd6, 32'd3, 32'h0000_0021, 8'h46, 1'b1, 1'b1, 32'd6, 1'b0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 8'h47, 1'b1, 1'b1, 32'd0, 1'b0);
    issue(4'd8, 32'd5, 32'hFFFF_FFFB, 8'h48, 1'b1, 1'b1, 32'd1, 1'b0);
    repeat (2) @(negedge clk);

    // Back-to-back multiplies, never held
    issue(4'd2, 32'd10, 32'd10, 8'h50, 1'b1, 1'b1, 32'd100, 1'b0);
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h51, 1'b1, 1'b1, 32'd1, 1'b0);
    issue(4'd2, 32'h8000_0000, 32'd1, 8'h52, 1'b1, 1'b1, 32'h8000_0000, 1'b0);
    repeat (5) @(negedge clk);

    // Illegal opcode: consumed, pulse only, no result
    issue(4'd12, 32'd1, 32'd1, 8'h60, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("illegal_pulse", illegal_op, 1'b1);
    chk("illegal_no_res", res_valid, 1'b0);
    @(negedge clk);
    chk("illegal_once", illegal_op, 1'b0);
    chk("sb_drained", sb.size(), 0);

    // Reset with two multiplies in flight
    issue(4'd2, 32'd2, 32'd3, 8'h70, 1'b1, 1'b0, 32'd0, 1'b0);
    issue(4'd2, 32'd4, 32'd5, 8'h71, 1'b1, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", res_valid, 1'b0);
    chk("mid_rst_data", res_data, 32'h0);
    chk("mid_rst_user", res_user, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    issue(4'd0, 32'd1, 32'd1, 8'h72, 1'b1, 1'b1, 32'd2, 1'b0);

    repeat (6) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fcore_multicycle_alu.md
# fcore_multicycle_alu

Parametrised integer ALU for the fcore datapath, the successor to the fixed floating-point ALU wrapper. It accepts operands and an opcode over AXI-stream, executes single-cycle logic/add ops and a multi-cycle multiply, and merges all results onto one writeback stream tagged with the destination register address. Writeback-slot reservation back-pressures the issue port so two results never complete in the same cycle.

## Interface
- DATA_WIDTH, 32: operand/result width.
- REGISTER_ADDR_WIDTH, 8: destination address width carried in `user`.
- MUL_LATENCY, 3: multiply issue-to-result cycles; legal range 2..8.
- SATURATE, 0: 1 = signed saturation on add/sub/mul; 0 = wrap (low DATA_WIDTH bits).
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- operand_a  axi_stream.slave  DATA_WIDTH  operand A; `user` = destination address.
- operand_b  axi_stream.slave  DATA_WIDTH  operand B.
- operation  axi_stream.slave  4  opcode in data[3:0].
- result  axi_stream.master  DATA_WIDTH  result; `user` = destination address; `ready` ignored.
- overflow  out  1  pulse aligned with result.valid when saturation/wrap overflow occurred.
- illegal_op  out  1  one-cycle pulse when an undefined opcode is consumed.

## Operation
- Issue: fire = operand_a.valid & operand_b.valid & operation.valid & issue_ready. The three slave `ready` outputs are identical (= issue_ready). Operands are signed two's complement.
- Opcodes: 0 ADD, 1 SUB (a-b), 2 MUL, 3 AND, 4 OR, 5 XOR, 6 SHL (a << b[4:0]), 7 SAR (arithmetic a >> b[4:0]), 8 CMPGT (result 1 if a>b else 0). 9..15 are illegal.
- Fast class (0,1,3..8): latency 1. Slow class (2): latency MUL_LATENCY, pipelined with one issue per cycle allowed.
- Address tag: operand_a.user is captured on fire and travels with the op through its pipeline.
- Writeback reservation: a shift register of MUL_LATENCY bits marks in-flight multiplies. A fast op issued at cycle t completes at t+1, colliding with a multiply issued at t+1-MUL_LATENCY. issue_ready = !(fast opcode presented & multiply stage MUL_LATENCY-1 valid). issue_ready may depend on the presented opcode; masters must not wait for ready before asserting valid. Multiplies are never stalled.
- Results may complete out of issue order; consumers rely on `user`.
- Arithmetic:
  - ADD/SUB use DATA_WIDTH+1 bit internally. Overflow = sign mismatch of the extra bit.
  - MUL forms the full 2*DATA_WIDTH product. Overflow = upper bits not a sign extension of bit DATA_WIDTH-1.
  - SATURATE=1 clamps to 0x7FFF_FFFF / 0x8000_0000 (for DATA_WIDTH=32). SATURATE=0 outputs the low bits.
  - overflow is asserted in both modes.
- Illegal opcode: the op is consumed (fire), no result is produced, and illegal_op pulses at fire+1.

## Timing
- Reset values:
  - result.valid, result.data, result.user, overflow, illegal_op = 0.
  - All pipeline valids and reservation bits = 0.
  - issue_ready = 1.
- ADD at cycle t → result.valid at t+1. MUL at cycle t → result.valid at t+MUL_LATENCY.
- result.valid, overflow and illegal_op are single-cycle pulses per op. There is no result holding: a result is lost if the consumer is not listening.
- Back-to-back: one op per cycle sustained for a uniform op class.
- Simultaneous fast op and multiply completion is impossible by construction. A bench assertion checks that no two pipeline outputs are valid in the same cycle.
- Stall release: a fast op held by issue_ready=0 issues in the following cycle (the slot frees as the multiply retires).
- Reset asserted mid-operation: all in-flight ops are discarded and no result is emitted after reset deassertion. Issue resumes on the first clock after release.

## Test plan
- ADD a=5, b=7, user=0x12 → result 12, user 0x12 at t+1; overflow=0.
- MUL a=-3, b=4, user=0x05, MUL_LATENCY=3 → result -12 (0xFFFFFFF4) at t+3.
- MUL issued at t, then ADD presented at t+2 → ready=0 at t+2; ADD issues at t+3; MUL result at t+3; ADD result at t+4; no cycle with two results.
- SATURATE=1, ADD 0x7FFFFFFF+1 → 0x7FFFFFFF, overflow=1. SATURATE=0 → 0x80000000, overflow=1.
- Opcode 12 → consumed, illegal_op pulse at t+1, no result.valid.
- Two multiplies in flight, reset low for 1 cycle → all outputs 0, no result afterwards; a new ADD 1+1 issued after release → 2 at t+1.
